// File: rtl/neural_pkg.sv
// Shared types and default widths for the neuron datapath and its sequencer.
package neural_pkg;

  localparam int NUM_INPUTS_DEF = 49;
  localparam int W_WEIGHT_DEF   = 32;
  localparam int W_PIXEL_DEF    = 8;
  localparam int W_BIAS_DEF     = 32;
  localparam int W_RESULT_DEF   = 32;
  localparam int W_ADDR_DEF     = 16;
  localparam int NEURON_LAT_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_BIAS,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/neuron_seq_addr_gen.sv
// Beat counter and shared read-address generator for the neuron sequencer.
module neuron_seq_addr_gen
  import neural_pkg::*;
#(
  parameter int NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int W_ADDR     = W_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [W_ADDR-1:0] base_addr,
  input  logic              addr_inc,
  input  logic              beat_inc,
  output logic [W_ADDR-1:0] addr,
  output logic              last_beat
);

  localparam int W_BEAT = $clog2(NUM_INPUTS + 1);

  logic [W_ADDR-1:0] addr_reg;
  logic [W_BEAT-1:0] beat_reg;

  // Address wraps naturally at 2^W_ADDR.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_reg <= '0;
      beat_reg <= '0;
    end else begin
      if (load)
        addr_reg <= base_addr;
      else if (addr_inc)
        addr_reg <= addr_reg + W_ADDR'(1);

      if (load)
        beat_reg <= '0;
      else if (beat_inc)
        beat_reg <= beat_reg + W_BEAT'(1);
    end
  end

  assign addr      = addr_reg;
  assign last_beat = (beat_reg == W_BEAT'(NUM_INPUTS - 1));

endmodule

// File: rtl/neuron_sequencer.sv
// Drives one neuron evaluation: clear, bias load, NUM_INPUTS product beats, drain, result hand-off.
// Optional macro NEURON_SEQ_RELU_EN clamps negative captured results to zero.
module neuron_sequencer
  import neural_pkg::*;
#(
  parameter int NUM_INPUTS   = NUM_INPUTS_DEF,
  parameter int W_WEIGHT     = W_WEIGHT_DEF,
  parameter int W_PIXEL_DATA = W_PIXEL_DEF,
  parameter int W_BIAS       = W_BIAS_DEF,
  parameter int W_RESULT     = W_RESULT_DEF,
  parameter int W_ADDR       = W_ADDR_DEF,
  parameter int NEURON_LAT   = NEURON_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [W_ADDR-1:0]       base_addr,
  input  logic [W_BIAS-1:0]       bias_in,
  output logic                    busy,
  output logic                    rd_en,
  output logic [W_ADDR-1:0]       rd_addr,
  input  logic [W_WEIGHT-1:0]     w_rd_data,
  input  logic [W_PIXEL_DATA-1:0] p_rd_data,
  output logic                    clear,
  output logic                    set_bias,
  output logic [W_BIAS-1:0]       bias,
  output logic                    active,
  output logic [W_WEIGHT-1:0]     weight,
  output logic [W_PIXEL_DATA-1:0] pixel,
  input  logic [W_RESULT-1:0]     sigma,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [W_RESULT-1:0]     result
);

  localparam int W_LAT = $clog2(NEURON_LAT + 1);

  seq_state_t          state_reg, state_next;
  logic [W_BIAS-1:0]   bias_reg;
  logic [W_RESULT-1:0] result_reg;
  logic [W_LAT-1:0]    lat_cnt_reg;

  logic                clear_next, set_bias_next, active_next, rd_en_next;
  logic                load, beat_inc, last_beat, drain_last;
  logic [W_ADDR-1:0]   addr;
  logic [W_RESULT-1:0] sigma_post;

  neuron_seq_addr_gen #(
    .NUM_INPUTS (NUM_INPUTS),
    .W_ADDR     (W_ADDR)
  ) u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .load      (load),
    .base_addr (base_addr),
    .addr_inc  (rd_en_next),
    .beat_inc  (beat_inc),
    .addr      (addr),
    .last_beat (last_beat)
  );

`ifdef NEURON_SEQ_RELU_EN
  assign sigma_post = sigma[W_RESULT-1] ? '0 : sigma;
`else
  assign sigma_post = sigma;
`endif

  assign drain_last = (lat_cnt_reg == W_LAT'(NEURON_LAT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_IDLE;
      bias_reg    <= '0;
      result_reg  <= '0;
      lat_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load)
        bias_reg <= bias_in;
      if (state_reg == ST_DRAIN && drain_last)
        result_reg <= sigma_post;
      if (state_reg == ST_DRAIN)
        lat_cnt_reg <= lat_cnt_reg + W_LAT'(1);
      else
        lat_cnt_reg <= '0;
    end
  end

  always_comb begin
    state_next    = state_reg;
    clear_next    = 1'b0;
    set_bias_next = 1'b0;
    active_next   = 1'b0;
    rd_en_next    = 1'b0;
    load          = 1'b0;
    beat_inc      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clear_next = 1'b1;
        state_next = ST_BIAS;
      end
      ST_BIAS: begin
        set_bias_next = 1'b1;
        rd_en_next    = 1'b1;
        state_next    = ST_STREAM;
      end
      ST_STREAM: begin
        // Prefetch the next operand on every beat except the last one.
        active_next = 1'b1;
        beat_inc    = 1'b1;
        rd_en_next  = !last_beat;
        if (last_beat)
          state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_last)
          state_next = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state_reg != ST_IDLE);
  assign res_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign clear     = clear_next;
  assign set_bias  = set_bias_next;
  assign active    = active_next;
  assign rd_en     = rd_en_next;
  assign rd_addr   = rd_en_next ? addr : '0;
  assign bias      = set_bias_next ? bias_reg : '0;
  assign weight    = active_next ? w_rd_data : '0;
  assign pixel     = active_next ? p_rd_data : '0;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench for neuron_sequencer with a registered memory model and a simple neuron accumulator.
module tb_neuron_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] base_addr;
  logic [31:0] bias_in;
  logic        busy, rd_en, clear, set_bias, active, res_valid, res_ready;
  logic [15:0] rd_addr;
  logic [31:0] w_rd_data = '0;
  logic [7:0]  p_rd_data = '0;
  logic [31:0] bias, weight, result, sigma;
  logic [7:0]  pixel;
  logic [31:0] acc = '0;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] W_VAL = 32'd1;
  localparam logic [7:0]  P_VAL = 8'd2;

  neuron_sequencer dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .bias_in   (bias_in),
    .busy      (busy),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .w_rd_data (w_rd_data),
    .p_rd_data (p_rd_data),
    .clear     (clear),
    .set_bias  (set_bias),
    .bias      (bias),
    .active    (active),
    .weight    (weight),
    .pixel     (pixel),
    .sigma     (sigma),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Memory: constant contents, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      w_rd_data <= W_VAL;
      p_rd_data <= P_VAL;
    end
  end

  // Neuron: sigma is the accumulator register, valid one cycle after the last active beat.
  always @(posedge clk) begin
    if (clear)         acc <= '0;
    else if (set_bias) acc <= bias;
    else if (active)   acc <= acc + weight * {24'd0, pixel};
  end
  assign sigma = acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_rd_en"},     rd_en, 0);
    chk({tag, "_rd_addr"},   rd_addr, 0);
    chk({tag, "_clear"},     clear, 0);
    chk({tag, "_set_bias"},  set_bias, 0);
    chk({tag, "_bias"},      bias, 0);
    chk({tag, "_active"},    active, 0);
    chk({tag, "_weight"},    weight, 0);
    chk({tag, "_pixel"},     pixel, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_result"},    result, 0);
  endtask

  // Issues one command and checks every cycle up to the result hand-off.
  task automatic run_cmd(input logic [15:0] base, input logic [31:0] bias_v,
                         input logic [31:0] exp_res, input int hold);
    logic        e_clear, e_set, e_act, e_rd, e_valid;
    logic [15:0] e_addr;
    base_addr = base;
    bias_in   = bias_v;
    start     = 1'b1;
    for (int c = 1; c <= 53; c++) begin
      step();
      start   = 1'b0;
      e_clear = (c == 1);
      e_set   = (c == 2);
      e_act   = (c >= 3 && c <= 51);
      e_rd    = (c >= 2 && c <= 50);
      e_valid = (c == 53);
      e_addr  = base + 16'(c - 2);
      chk("clear", clear, e_clear);
      chk("set_bias", set_bias, e_set);
      chk("active", active, e_act);
      chk("rd_en", rd_en, e_rd);
      chk("res_valid", res_valid, e_valid);
      chk("busy", busy, 1);
      if (e_rd)  chk("rd_addr", rd_addr, e_addr);
      if (e_set) chk("bias", bias, bias_v);
      chk("weight", weight, e_act ? W_VAL : 32'd0);
      chk("pixel", pixel, e_act ? P_VAL : 8'd0);
      if (e_valid) chk("result", result, exp_res);
      $display("cmd base=%h cycle=%0d clear=%b set_bias=%b active=%b rd_en=%b rd_addr=%h res_valid=%b",
               base, c, clear, set_bias, active, rd_en, rd_addr, res_valid);
    end
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      start     = h[0];
      step();
      chk("hold_valid", res_valid, 1);
      chk("hold_result", result, exp_res);
      chk("hold_rd_en", rd_en, 0);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("xfer_valid", res_valid, 0);
    chk("xfer_busy", busy, 0);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_clear", clear, 0);
    $display("cmd base=%h done result=%h", base, result);
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    bias_in   = '0;
    res_ready = 1'b0;
    #2;
    chk_all_zero("reset");
    step();
    rstn = 1'b1;
    step();
    chk("post_reset_busy", busy, 0);

    // Basic run: bias 5 plus 49 products of 1*2.
    run_cmd(16'h0010, 32'd5, 32'd103, 10);

    // Address wrap: 0xFFF0 .. 0xFFFF, 0x0000 .. 0x0020.
    run_cmd(16'hFFF0, 32'd5, 32'd103, 0);

    // Reset in the middle of the stream (beat 20).
    base_addr = 16'h0010;
    bias_in   = 32'd5;
    start     = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      step();
      start = 1'b0;
    end
    chk("beat20_active", active, 1);
    chk("beat20_rd_addr", rd_addr, 16'h0025);
    rstn = 1'b0;
    #1;
    chk_all_zero("midrst");
    step();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("quiet_busy", busy, 0);
      chk("quiet_rd_en", rd_en, 0);
    end
    run_cmd(16'h0010, 32'd5, 32'd103, 2);

    // Negative sigma: 0xFFFFFE9E + 98 = 0xFFFFFF00.
`ifdef NEURON_SEQ_RELU_EN
    run_cmd(16'h0100, 32'hFFFF_FE9E, 32'h0000_0000, 1);
`else
    run_cmd(16'h0100, 32'hFFFF_FE9E, 32'hFFFF_FF00, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 SHALL have parameters: NUM_INPUTS default 49 (products per neuron evaluation); W_WEIGHT default 32 (weight width); W_PIXEL_DATA default 8 (pixel width); W_BIAS default 32 (bias width); W_RESULT default 32 (sigma/result width); W_ADDR default 16 (memory address width); NEURON_LAT default 1 (cycles from last active beat to valid sigma).
REQ-002 SHALL have ports:
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  command request, sampled in IDLE only
- base_addr  in  W_ADDR  first weight/pixel address
- bias_in  in  W_BIAS  bias for this evaluation
- busy  out  1  high in every state except IDLE
- rd_en  out  1  read strobe to weight and pixel memories
- rd_addr  out  W_ADDR  shared read address
- w_rd_data  in  W_WEIGHT  weight, valid 1 cycle after rd_en
- p_rd_data  in  W_PIXEL_DATA  pixel, valid 1 cycle after rd_en
- clear  out  1  neuron accumulator clear
- set_bias  out  1  neuron bias load
- bias  out  W_BIAS  bias to neuron
- active  out  1  neuron accumulate enable
- weight  out  W_WEIGHT  weight to neuron
- pixel  out  W_PIXEL_DATA  pixel to neuron
- sigma  in  W_RESULT  neuron result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- result  out  W_RESULT  captured result

Function
REQ-003 SHALL implement FSM states IDLE, CLEAR, BIAS, STREAM, DRAIN, DONE.
REQ-004 IDLE: start=1 latches base_addr and bias_in -> CLEAR next cycle; start is ignored in all other states.
REQ-005 CLEAR: clear=1 for exactly one cycle -> BIAS.
REQ-006 BIAS: set_bias=1 for exactly one cycle with bias = latched value; rd_en=1, rd_addr=base_addr -> STREAM.
REQ-007 STREAM: exactly NUM_INPUTS cycles; active=1, weight=w_rd_data, pixel=p_rd_data (combinational pass-through); rd_en=1 with rd_addr=base_addr+k+1 on stream beat k for k=0..NUM_INPUTS-2, rd_en=0 on last beat.
REQ-008 rd_addr SHALL wrap modulo 2^W_ADDR without error.
REQ-009 DRAIN: active=0 for NEURON_LAT cycles; on last DRAIN cycle capture sigma (post-processed per REQ-015) into result -> DONE.
REQ-010 DONE: res_valid=1, result stable until res_valid&&res_ready; transfer cycle -> IDLE; start sampled again from the following cycle.
REQ-011 clear, set_bias and active SHALL be mutually exclusive in every cycle; weight and pixel SHALL be 0 whenever active=0.
REQ-012 Start-to-res_valid latency SHALL be 2+NUM_INPUTS+NEURON_LAT+1 cycles (53 at defaults).
REQ-013 rd_en SHALL be 0 in IDLE, CLEAR, DRAIN, DONE.

Reset
REQ-014 rstn=0 SHALL asynchronously force IDLE and zero busy, rd_en, rd_addr, clear, set_bias, bias, active, weight, pixel, res_valid, result and latched registers, including mid-STREAM; after release, no output toggles until a new start.

Configuration
REQ-015 Macro NEURON_SEQ_RELU_EN: defined -> captured result = 0 if sigma is negative (two's complement MSB=1), else sigma; undefined -> result = sigma unmodified.

Structure
REQ-016 Shared package neural_pkg SHALL hold the FSM state enum and default width constants; default widths SHALL match those used by the Neuron block.
REQ-017 One sub-module neuron_seq_addr_gen SHALL hold the beat counter and address generator (load base, increment, last-beat flag).

Verification
REQ-018 Benches SHALL cover:
- start with base_addr=0x0010, bias_in=0x0000_0005 -> clear at cycle 1, set_bias with bias=5 at cycle 2, active for 49 cycles, rd_addr 0x0010..0x0040, res_valid at cycle 53.
- memory model with weight=1 and pixel=2 at all addresses, Neuron model attached -> result = 5+49*2 = 103.
- res_ready held 0 for 10 cycles in DONE -> res_valid and result stable; start pulses during this ignored; res_ready=1 -> IDLE next cycle.
- base_addr=0xFFF0 -> rd_addr wraps 0xFFFF -> 0x0000, last address 0x0020.
- rstn=0 at stream beat 20 -> all outputs 0 immediately; next start produces full correct sequence.
- NEURON_SEQ_RELU_EN defined, neuron sigma=0xFFFF_FF00 -> result=0; undefined -> result=0xFFFF_FF00.
